// File: rtl/totp_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : totp_sequencer_if
// Brief    : Link between the TOTP sequencer and the HOTP core. The sequencer
//            supplies the step counter and the core reset. The core returns
//            its 20-bit code and a level done flag.
// Revision : 1.0 - initial release
// ============================================================================
interface totp_sequencer_if;
    logic [63:0] hotp_counter;
    logic        hotp_reset;
    logic [19:0] hotp_code;
    logic        hotp_done;

    // Sequencer side
    modport master (
        output hotp_counter,
        output hotp_reset,
        input  hotp_code,
        input  hotp_done
    );

    // HOTP core side
    modport slave (
        input  hotp_counter,
        input  hotp_reset,
        output hotp_code,
        output hotp_done
    );
endinterface
`default_nettype wire

// File: rtl/totp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : totp_sequencer
// Brief    : RFC-6238 TOTP front end for an HOTP core. It keeps Unix seconds
//            and derives the step counter T = (time - T0) / STEP_SECONDS with
//            a serial restoring divider. It restarts the HOTP core whenever T
//            changes, then captures and holds the resulting code.
// Revision : 1.0 - initial release
// ============================================================================
module totp_sequencer #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned STEP_SECONDS = 30,
    parameter logic [63:0] T0           = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             time_load,
    input  logic [63:0]      time_value,
    totp_sequencer_if.master hotp,
    output logic [19:0]      code,
    output logic             code_valid,
    output logic [7:0]       seconds_left
);

    localparam int            c_PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(CLK_HZ - 1);
    localparam logic [7:0]    c_STEP      = 8'(STEP_SECONDS);
    localparam logic [7:0]    c_STEP_LAST = 8'(STEP_SECONDS - 1);
    localparam logic [8:0]    c_STEP9     = 9'(STEP_SECONDS);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_DIVIDE = 3'd1;
    localparam logic [2:0] c_START  = 3'd2;
    localparam logic [2:0] c_HASH   = 3'd3;
    localparam logic [2:0] c_HOLD   = 3'd4;

    logic [2:0]         r_state;
    logic [c_PRE_W-1:0] r_prescaler;
    logic [63:0]        r_unix_time;
    logic [7:0]         r_sub_sec;
    // r_step_t always tracks the true current T. r_hotp_counter only follows
    // it when the core is restarted, so the core never sees a moving counter.
    logic [63:0]        r_step_t;
    logic [63:0]        r_hotp_counter;
    logic               r_hotp_reset;
    logic [19:0]        r_code;
    logic               r_code_valid;
    logic               r_pending;
    logic [63:0]        r_div_q;
    logic [7:0]         r_div_rem;
    logic [5:0]         r_div_cnt;

    logic               w_running;
    logic               w_tick;
    logic               w_step;
    logic [63:0]        w_step_t_next;
    logic [64:0]        w_diff;
    logic [63:0]        w_dividend;
    logic [8:0]         w_rem_shift;
    logic               w_rem_ge;
    logic [7:0]         w_rem_next;
    logic [63:0]        w_quo_next;

    // The clock only runs once a time has been loaded and divided.
    assign w_running     = (r_state == c_START) || (r_state == c_HASH) || (r_state == c_HOLD);
    assign w_tick        = w_running && (r_prescaler == c_PRE_MAX);
    assign w_step        = w_tick && (r_sub_sec == c_STEP_LAST);
    assign w_step_t_next = w_step ? (r_step_t + 64'd1) : r_step_t;

    // Bit 64 is the borrow. A time earlier than T0 divides as zero.
    assign w_diff     = {1'b0, time_value} - {1'b0, T0};
    assign w_dividend = w_diff[64] ? 64'd0 : w_diff[63:0];

    // One restoring-division step. The remainder is always below STEP_SECONDS,
    // so 8 bits of the trial subtraction are exact.
    assign w_rem_shift = {r_div_rem, r_div_q[63]};
    assign w_rem_ge    = (w_rem_shift >= c_STEP9);
    assign w_rem_next  = w_rem_ge ? (w_rem_shift[7:0] - c_STEP) : w_rem_shift[7:0];
    assign w_quo_next  = {r_div_q[62:0], w_rem_ge};

    // Sequencer FSM, timekeeping and serial divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_prescaler    <= '0;
            r_unix_time    <= 64'd0;
            r_sub_sec      <= 8'd0;
            r_step_t       <= 64'd0;
            r_hotp_counter <= 64'd0;
            r_hotp_reset   <= 1'b1;
            r_code         <= 20'd0;
            r_code_valid   <= 1'b0;
            r_pending      <= 1'b0;
            r_div_q        <= 64'd0;
            r_div_rem      <= 8'd0;
            r_div_cnt      <= 6'd0;
        end else if (time_load) begin
            // A new time aborts any operation and wins over a tick or done.
            r_unix_time  <= time_value;
            r_div_q      <= w_dividend;
            r_div_rem    <= 8'd0;
            r_div_cnt    <= 6'd0;
            r_prescaler  <= '0;
            r_code_valid <= 1'b0;
            r_pending    <= 1'b0;
            r_hotp_reset <= 1'b1;
            r_state      <= c_DIVIDE;
        end else begin
            if (w_running) begin
                r_prescaler <= w_tick ? '0 : (r_prescaler + 1'b1);
                if (w_tick) begin
                    r_unix_time <= r_unix_time + 64'd1;
                    r_sub_sec   <= w_step ? 8'd0 : (r_sub_sec + 8'd1);
                end
                r_step_t <= w_step_t_next;
            end
            case (r_state)
                c_IDLE: begin
                    r_hotp_reset <= 1'b1;
                end
                c_DIVIDE: begin
                    r_div_q   <= w_quo_next;
                    r_div_rem <= w_rem_next;
                    r_div_cnt <= r_div_cnt + 6'd1;
                    if (r_div_cnt == 6'd63) begin
                        r_hotp_counter <= w_quo_next;
                        r_step_t       <= w_quo_next;
                        r_sub_sec      <= w_rem_next;
                        r_state        <= c_START;
                    end
                end
                c_START: begin
                    // A step landing here makes the hash stale before it starts.
                    if (w_step) begin
                        r_pending <= 1'b1;
                    end
                    r_hotp_reset <= 1'b0;
                    r_state      <= c_HASH;
                end
                c_HASH: begin
                    if (hotp.hotp_done) begin
                        if (r_pending || w_step) begin
                            r_pending      <= 1'b0;
                            r_hotp_counter <= w_step_t_next;
                            r_hotp_reset   <= 1'b1;
                            r_state        <= c_START;
                        end else begin
                            r_code       <= hotp.hotp_code;
                            r_code_valid <= 1'b1;
                            r_state      <= c_HOLD;
                        end
                    end else if (w_step) begin
                        r_pending <= 1'b1;
                    end
                end
                c_HOLD: begin
                    if (w_step) begin
                        r_code_valid   <= 1'b0;
                        r_hotp_counter <= w_step_t_next;
                        r_hotp_reset   <= 1'b1;
                        r_state        <= c_START;
                    end
                end
                default: begin
                    r_hotp_reset <= 1'b1;
                    r_state      <= c_IDLE;
                end
            endcase
        end
    end

    assign hotp.hotp_counter = r_hotp_counter;
    assign hotp.hotp_reset   = r_hotp_reset;
    assign code              = r_code;
    assign code_valid        = r_code_valid;
    assign seconds_left      = (r_state == c_IDLE) ? 8'd0 : (c_STEP - r_sub_sec);

endmodule
`default_nettype wire

// File: tb/tb_totp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_totp_sequencer
// Brief    : Self-checking bench for totp_sequencer. Two instances are used:
//            A with T0=0 and B with T0=100. Each has a stub HOTP core whose
//            codes are the published HOTP values for the key
//            "12345678901234567890" at the counters that are exercised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_totp_sequencer;

    localparam int CLK_HZ = 4;
    localparam int STEP   = 30;

    logic        clk;
    logic        reset;
    logic        ld_a, ld_b;
    logic [63:0] tv;
    logic [19:0] code_a, code_b;
    logic        cv_a, cv_b;
    logic [7:0]  sl_a, sl_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    totp_sequencer_if ha ();
    totp_sequencer_if hb ();

    totp_sequencer #(.CLK_HZ(CLK_HZ), .STEP_SECONDS(STEP), .T0(64'd0)) dut_a (
        .clk(clk), .reset(reset), .time_load(ld_a), .time_value(tv), .hotp(ha),
        .code(code_a), .code_valid(cv_a), .seconds_left(sl_a));

    totp_sequencer #(.CLK_HZ(CLK_HZ), .STEP_SECONDS(STEP), .T0(64'd100)) dut_b (
        .clk(clk), .reset(reset), .time_load(ld_b), .time_value(tv), .hotp(hb),
        .code(code_b), .code_valid(cv_b), .seconds_left(sl_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known 6-digit HOTP codes for the RFC test key. Any other counter gets an
    // arbitrary but deterministic code.
    function automatic logic [19:0] hotp_ref(input logic [63:0] c);
        logic [63:0] f;
        case (c)
            64'd0:        return 20'd755224;
            64'd1:        return 20'd287082;
            64'd2:        return 20'd359152;
            64'd3:        return 20'd969429;
            64'h23523EC:  return 20'd81804;
            64'h23523ED:  return 20'd50471;
            64'h273EF07:  return 20'd5924;
            default: begin
                f = (c * 64'd7919 + 64'd13) % 64'd1000000;
                return f[19:0];
            end
        endcase
    endfunction

    function automatic logic [63:0] base_of(input logic [63:0] t, input logic [63:0] t0);
        return (t >= t0) ? (t - t0) : 64'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stub HOTP cores: done rises lat cycles after the core leaves reset.
    int lat_a = 1;
    int cnt_a = 0;
    int cnt_b = 0;
    always @(posedge clk) begin
        if (ha.hotp_reset === 1'b1) begin
            cnt_a        <= 0;
            ha.hotp_done <= 1'b0;
        end else begin
            cnt_a        <= cnt_a + 1;
            ha.hotp_done <= (cnt_a + 1 >= lat_a);
        end
    end
    always @(posedge clk) begin
        if (hb.hotp_reset === 1'b1) begin
            cnt_b        <= 0;
            hb.hotp_done <= 1'b0;
        end else begin
            cnt_b        <= cnt_b + 1;
            hb.hotp_done <= (cnt_b + 1 >= 1);
        end
    end
    assign ha.hotp_code = hotp_ref(ha.hotp_counter);
    assign hb.hotp_code = hotp_ref(hb.hotp_counter);

    // Time model for instance A: m_n counts edges since the load edge. The
    // seconds clock starts when the 64-cycle divide completes, and one second
    // then passes every CLK_HZ cycles.
    bit          m_loaded = 0;
    int          m_n = 0;
    logic [63:0] m_base = 64'd0;
    always @(posedge clk) begin
        if (reset) begin
            m_loaded <= 1'b0;
        end else if (ld_a) begin
            m_loaded <= 1'b1;
            m_n      <= 0;
            m_base   <= base_of(tv, 64'd0);
        end else if (m_loaded) begin
            m_n <= m_n + 1;
        end
    end

    // Per-cycle comparison of instance A against the time model.
    always @(negedge clk) begin : p_cmp
        logic [63:0] eff;
        if (chk_en) begin
            if (!m_loaded) begin
                check("idle_hotp_reset", ha.hotp_reset, 1);
                check("idle_counter", ha.hotp_counter, 0);
                check("idle_code", code_a, 0);
                check("idle_valid", cv_a, 0);
                check("idle_seconds_left", sl_a, 0);
            end else begin
                if (m_n <= 64) check("divide_hotp_reset", ha.hotp_reset, 1);
                if (m_n <= 65) check("early_valid", cv_a, 0);
                if (m_n >= 64) begin
                    eff = m_base + 64'((m_n - 64) / CLK_HZ);
                    check("seconds_left", sl_a, 64'(STEP) - (eff % 64'(STEP)));
                    if (cv_a === 1'b1) begin
                        check("valid_counter", ha.hotp_counter, eff / 64'(STEP));
                        check("valid_code", code_a, hotp_ref(eff / 64'(STEP)));
                    end
                end
            end
        end
    end

    task automatic load_a(input logic [63:0] v);
        @(negedge clk);
        tv = v; ld_a = 1'b1;
        @(negedge clk);
        ld_a = 1'b0;
    endtask

    task automatic load_b(input logic [63:0] v);
        @(negedge clk);
        tv = v; ld_b = 1'b1;
        @(negedge clk);
        ld_b = 1'b0;
    endtask

    task automatic wait_valid_a(input int bound, output int waited);
        waited = 0;
        while (cv_a !== 1'b1 && waited < bound) begin
            @(negedge clk);
            waited++;
        end
        check("wait_valid_a", cv_a, 1);
    endtask

    task automatic wait_valid_b(input int bound);
        int w;
        w = 0;
        while (cv_b !== 1'b1 && w < bound) begin
            @(negedge clk);
            w++;
        end
        check("wait_valid_b", cv_b, 1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, hi, rises;
        logic prev;
        reset = 1'b1; ld_a = 1'b0; ld_b = 1'b0; tv = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_hotp_reset_b", hb.hotp_reset, 1);
        check("rst_valid_b", cv_b, 0);
        check("rst_seconds_left_b", sl_b, 0);
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Load 59: T=1, 29 s into the step.
        load_a(64'd59);
        wait_valid_a(200, w);
        check("t59_latency", w, 67);
        check("t59_code", code_a, 287082);
        check("t59_counter", ha.hotp_counter, 1);
        check("t59_seconds_left", sl_a, 1);
        @(negedge clk);
        check("t59_roll_valid", cv_a, 0);
        check("t59_roll_code_held", code_a, 287082);
        wait_valid_a(50, w);
        check("t60_rehash_latency", w, 3);
        check("t60_code", code_a, 359152);

        // Load 1111111109: last second of step 0x23523EC.
        load_a(64'd1111111109);
        wait_valid_a(200, w);
        check("t1111_code", code_a, 81804);
        check("t1111_counter", ha.hotp_counter, 64'h23523EC);
        @(negedge clk);
        check("t1111_roll_valid", cv_a, 0);
        wait_valid_a(50, w);
        check("t1111_next_code", code_a, 50471);
        check("t1111_next_counter", ha.hotp_counter, 64'h23523ED);

        // Abort a slow hash with a new load. Done rises on the load edge.
        lat_a = 20;
        load_a(64'd100);
        w = 0;
        while (ha.hotp_reset !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("abort_reach_hash", ha.hotp_reset, 0);
        repeat (2) @(negedge clk);
        lat_a = 1;
        load_a(64'd1234567890);
        hi = 0;
        while (ha.hotp_reset === 1'b1 && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        check("abort_reset_high_cycles", hi, 65);
        wait_valid_a(50, w);
        check("abort_code", code_a, 5924);
        check("abort_counter", ha.hotp_counter, 64'h273EF07);

        // A step event lands mid-hash: the result is discarded and the core
        // is restarted once.
        lat_a = 10;
        load_a(64'd59);
        rises = 0;
        prev  = ha.hotp_reset;
        w     = 0;
        while (cv_a !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
            if (ha.hotp_reset === 1'b1 && prev === 1'b0) rises++;
            prev = ha.hotp_reset;
        end
        check("pend_valid", cv_a, 1);
        check("pend_latency", w, 88);
        check("pend_restarts", rises, 1);
        check("pend_code", code_a, 359152);
        check("pend_counter", ha.hotp_counter, 2);
        lat_a = 1;

        // Instance B, T0=100: 1111 -> T=33, rem 21; 50 -> before T0.
        load_b(64'd1111);
        repeat (64) @(negedge clk);
        check("b1111_counter", hb.hotp_counter, 33);
        check("b1111_seconds_left", sl_b, 9);
        wait_valid_b(50);
        check("b1111_code", code_b, hotp_ref(64'd33));
        load_b(64'd50);
        repeat (64) @(negedge clk);
        check("b50_counter", hb.hotp_counter, 0);
        check("b50_seconds_left", sl_b, 30);
        check("b50_hotp_reset", hb.hotp_reset, 1);
        wait_valid_b(50);
        check("b50_code", code_b, 755224);

        // Reset in the middle of a divide.
        load_a(64'd59);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_hotp_reset", ha.hotp_reset, 1);
        check("midrst_counter", ha.hotp_counter, 0);
        check("midrst_code", code_a, 0);
        check("midrst_valid", cv_a, 0);
        check("midrst_seconds_left", sl_a, 0);
        check("midrst_b_code", code_b, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
